// File: rtl/camera_pkg.sv
// Shared types and default timing for the camera clock/sensor bring-up sequencer.
// Output levels for each state live here so the sequencer and any status decoders agree.
package camera_pkg;

    typedef enum logic [3:0] {
        ST_OFF,
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_CAM_PWR,
        ST_CAM_RST,
        ST_CAM_WAIT,
        ST_RUN,
        ST_FAULT
    } cam_state_t;

    typedef struct packed {
        logic pll_reset;
        logic xclk_en;
        logic cam_pwdn;
        logic cam_rst_n;
        logic sys_rst;
        logic ready;
        logic fault;
    } cam_outs_t;

    localparam int DEF_CNT_W           = 20;
    localparam int DEF_PLL_RST_CYC     = 50;
    localparam int DEF_LOCK_TIMEOUT    = 50000;
    localparam int DEF_LOCK_STABLE_CYC = 1000;
    localparam int DEF_PWDN_CYC        = 5000;
    localparam int DEF_RST_CYC         = 5000;
    localparam int DEF_INIT_CYC        = 50000;
    localparam int DEF_MAX_RETRY       = 3;

    // Pin levels per state; anything not listed sits at the safe OFF levels.
    function automatic cam_outs_t decode_outs(input cam_state_t s);
        cam_outs_t o;
        o.pll_reset = 1'b1;
        o.xclk_en   = 1'b0;
        o.cam_pwdn  = 1'b1;
        o.cam_rst_n = 1'b0;
        o.sys_rst   = 1'b1;
        o.ready     = 1'b0;
        o.fault     = 1'b0;
        case (s)
            ST_WAIT_LOCK, ST_STABLE: begin
                o.pll_reset = 1'b0;
            end
            ST_CAM_PWR: begin
                o.pll_reset = 1'b0;
                o.xclk_en   = 1'b1;
            end
            ST_CAM_RST: begin
                o.pll_reset = 1'b0;
                o.xclk_en   = 1'b1;
                o.cam_pwdn  = 1'b0;
            end
            ST_CAM_WAIT: begin
                o.pll_reset = 1'b0;
                o.xclk_en   = 1'b1;
                o.cam_pwdn  = 1'b0;
                o.cam_rst_n = 1'b1;
            end
            ST_RUN: begin
                o.pll_reset = 1'b0;
                o.xclk_en   = 1'b1;
                o.cam_pwdn  = 1'b0;
                o.cam_rst_n = 1'b1;
                o.sys_rst   = 1'b0;
                o.ready     = 1'b1;
            end
            ST_FAULT: begin
                o.fault = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/camera_clk_seq_sync_2ff.sv
// Single-bit two-flop synchronizer, async reset to 0.
// Usable for any slow status bit crossing into the local clock.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/camera_clk_seq.sv
// Camera PLL and image-sensor power-up sequencer with lock qualification, retry and fault reporting.
// Outputs are decoded from the next state and registered, so pins move on the same edge as the state.
module camera_clk_seq
    import camera_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int PLL_RST_CYC     = DEF_PLL_RST_CYC,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int PWDN_CYC        = DEF_PWDN_CYC,
    parameter int RST_CYC         = DEF_RST_CYC,
    parameter int INIT_CYC        = DEF_INIT_CYC,
    parameter int MAX_RETRY       = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       xclk_en,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt
);

    logic             lock_s;
    cam_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [1:0]       retry_inc;
    cam_outs_t        outs_q, outs_d;
    logic             fail;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fail    = 1'b0;
        if (!enable) begin
            state_d = ST_OFF;
            retry_d = 2'd0;
        end else begin
            case (state_q)
                ST_OFF:     state_d = ST_PLL_RST;
                ST_PLL_RST: if (cnt_q == CNT_W'(PLL_RST_CYC - 1)) state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (lock_s)                                   state_d = ST_STABLE;
                    else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1))   fail = 1'b1;
                end
                // A lock glitch while qualifying only restarts the wait, it is not a failed attempt.
                ST_STABLE: begin
                    if (!lock_s)                                   state_d = ST_WAIT_LOCK;
                    else if (cnt_q == CNT_W'(LOCK_STABLE_CYC - 1)) state_d = ST_CAM_PWR;
                end
                ST_CAM_PWR: begin
                    if (!lock_s)                            fail = 1'b1;
                    else if (cnt_q == CNT_W'(PWDN_CYC - 1)) state_d = ST_CAM_RST;
                end
                ST_CAM_RST: begin
                    if (!lock_s)                           fail = 1'b1;
                    else if (cnt_q == CNT_W'(RST_CYC - 1)) state_d = ST_CAM_WAIT;
                end
                ST_CAM_WAIT: begin
                    if (!lock_s)                            fail = 1'b1;
                    else if (cnt_q == CNT_W'(INIT_CYC - 1)) state_d = ST_RUN;
                end
                ST_RUN:   if (!lock_s) fail = 1'b1;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_OFF;
            endcase

            if (fail) begin
                retry_d = retry_inc;
                state_d = (int'(retry_inc) == MAX_RETRY) ? ST_FAULT : ST_PLL_RST;
            end else if (state_d == ST_RUN && state_q != ST_RUN) begin
                retry_d = 2'd0;
            end
        end

        cnt_d  = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        outs_d = decode_outs(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            retry_q <= 2'd0;
            outs_q  <= decode_outs(ST_OFF);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            outs_q  <= outs_d;
        end
    end

    assign pll_reset = outs_q.pll_reset;
    assign xclk_en   = outs_q.xclk_en;
    assign cam_pwdn  = outs_q.cam_pwdn;
    assign cam_rst_n = outs_q.cam_rst_n;
    assign sys_rst   = outs_q.sys_rst;
    assign ready     = outs_q.ready;
    assign fault     = outs_q.fault;
    assign retry_cnt = retry_q;

endmodule

// File: doc/camera_clk_seq.md
# camera_clk_seq

Power-up and clock bring-up sequencer for the camera clock PLL and the image sensor. It runs on the free-running board clock and drives the camera PLL's reset and output-enable. It waits for a qualified PLL lock, then steps the sensor through power-down release and hardware reset. Only after that does it release the camera-domain logic reset. Loss of lock, lock timeout and retry exhaustion are detected and reported; the ISP top level uses `ready`/`fault` as its camera-path status.

## Interface
Parameters:
- `CNT_W`, 20 — width of the shared phase counter.
- `PLL_RST_CYC`, 50 — cycles `pll_reset` is held per attempt (≥1).
- `LOCK_TIMEOUT`, 50000 — cycles allowed in WAIT_LOCK before an attempt fails.
- `LOCK_STABLE_CYC`, 1000 — consecutive synchronized-lock cycles required.
- `PWDN_CYC`, 5000 — cycles with XCLK running and sensor still in power-down.
- `RST_CYC`, 5000 — sensor reset (`cam_rst_n`=0) duration.
- `INIT_CYC`, 50000 — wait after sensor reset release before RUN.
- `MAX_RETRY`, 3 — failed attempts (timeout or lock loss) before FAULT.

Ports:
- `clk`, in, 1 — board clock (PLL reference, 50 MHz). One clock; the reset below is asynchronous and active-high.
- `rst`, in, 1 — asynchronous, active-high reset.
- `enable`, in, 1 — level; 1 = bring up and keep running, 0 = shut down.
- `pll_lock`, in, 1 — PLL LOCK, asynchronous to `clk`.
- `pll_reset`, out, 1 — to PLL RESET.
- `xclk_en`, out, 1 — to PLL ENCLK0 (sensor XCLK gate).
- `cam_pwdn`, out, 1 — sensor power-down, active-high.
- `cam_rst_n`, out, 1 — sensor reset, active-low.
- `sys_rst`, out, 1 — camera-domain logic reset, active-high.
- `ready`, out, 1 — sequence complete, lock healthy.
- `fault`, out, 1 — retries exhausted.
- `retry_cnt`, out, 2 — failed attempts since last RUN entry, saturating at 3.

## Operation
- `pll_lock` passes through a 2-flop synchronizer (`lock_s`). This adds 2 cycles of latency.
- One `CNT_W` counter is cleared on every state entry. A timed state exits on the edge where `cnt == N-1`, so it is held for exactly N cycles.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state.
- OFF: `pll_reset`=1, `xclk_en`=0, `cam_pwdn`=1, `cam_rst_n`=0, `sys_rst`=1, `ready`=0. Goes to PLL_RST when `enable`=1.
- PLL_RST: `pll_reset`=1 for `PLL_RST_CYC` cycles, then WAIT_LOCK.
- WAIT_LOCK: `pll_reset`=0.
  - `lock_s`=1 goes to STABLE.
  - After `LOCK_TIMEOUT` cycles without lock: `retry_cnt`+1. If the new value equals `MAX_RETRY`, go to FAULT; otherwise go to PLL_RST.
- STABLE: requires `LOCK_STABLE_CYC` consecutive `lock_s`=1 cycles, then CAM_PWR. If `lock_s`=0, return to WAIT_LOCK with a fresh timeout; this is not counted as a retry.
- CAM_PWR: `xclk_en`=1, `cam_pwdn`=1, for `PWDN_CYC` cycles.
- CAM_RST: `cam_pwdn`=0, `cam_rst_n`=0, for `RST_CYC` cycles.
- CAM_WAIT: `cam_rst_n`=1, for `INIT_CYC` cycles.
- RUN: `sys_rst`=0, `ready`=1. `retry_cnt` clears on entry.
- Lock loss: `lock_s`=0 in CAM_PWR, CAM_RST, CAM_WAIT or RUN counts as a failed attempt.
  - Next state is PLL_RST with all sensor outputs returned to OFF values, or FAULT if the limit is reached.
  - `ready` and `sys_rst` update on that same edge.
- FAULT: OFF output values plus `fault`=1. Held until `enable`=0.
- `enable`=0 in any state goes to OFF on the next edge and clears `retry_cnt` and `fault`. This has priority over every other transition.

## Timing
- Reset values: state OFF, `pll_reset`=1, `xclk_en`=0, `cam_pwdn`=1, `cam_rst_n`=0, `sys_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0, synchronizer flops 0.
- Let E be the edge that enters PLL_RST. With lock already synchronized high, RUN is entered at E + `PLL_RST_CYC` + 1 + `LOCK_STABLE_CYC` + `PWDN_CYC` + `RST_CYC` + `INIT_CYC`.
- Lock drop to `ready`=0: 3 edges after `pll_lock` falls (2 synchronizer stages + 1 state register).
- Asserting `rst` mid-sequence returns all outputs to their reset values immediately, with no clock required.

## Structure
- A shared package `camera_pkg` holds the state enum (OFF, PLL_RST, WAIT_LOCK, STABLE, CAM_PWR, CAM_RST, CAM_WAIT, RUN, FAULT) and the default timing constants.
- One sub-module: `sync_2ff`, the single-bit 2-flop synchronizer with async reset to 0. It is reusable for other cross-domain status bits.

## Test plan
Parameters: `PLL_RST_CYC`=4, `LOCK_TIMEOUT`=16, `LOCK_STABLE_CYC`=8, `PWDN_CYC`=5, `RST_CYC`=6, `INIT_CYC`=10, `MAX_RETRY`=2. E is the edge entering PLL_RST.
- Happy path, `pll_lock`=1 throughout: `pll_reset` falls at E+4, `xclk_en` rises at E+13, `cam_pwdn` falls at E+18, `cam_rst_n` rises at E+24, `ready`=1 and `sys_rst`=0 at E+34.
- `pll_lock`=0 throughout: `retry_cnt`=1 at E+20 with `pll_reset`=1 again; `fault`=1 at E+40; outputs stay in OFF values.
- Lock glitch of 3 cycles during STABLE: the state returns to WAIT_LOCK, `retry_cnt` stays 0, and the 8-cycle stability count restarts after the glitch.
- `pll_lock` drops in RUN: `ready`=0 and `sys_rst`=1 3 edges later, `retry_cnt`=1, full re-sequence to RUN, then `retry_cnt`=0.
- `enable`=0 during CAM_RST and during FAULT: OFF on the next edge, `fault`=0, `retry_cnt`=0; re-enabling restarts from PLL_RST.
- Async `rst` pulse mid-CAM_WAIT, between clock edges: all outputs reach their reset values before the next edge.
